// File: rtl/zxtres_joy_db9_reader.sv
// zxtres_joy_db9_reader
// Serial reader for the ZXTRES DB9/JAMMA joystick shift-register chain.
// Each frame does the following:
//   - idles for FRAME_GAP cycles;
//   - pulses joy_load_n low for 2*CLK_DIV cycles;
//   - shifts in 24 active-low bits, one per joy_clk period of 2*CLK_DIV cycles;
//   - presents them as two active-high 12-bit words with a one-cycle frame_valid pulse.
//
// Ports:
//   clk_sys     - system clock
//   reset       - synchronous active-high reset
//   joy_clk     - shift clock to the external registers, idles low
//   joy_load_n  - parallel-load strobe, active low
//   joy_data    - serial data from the chain, active low, asynchronous
//   joy_select  - constant 1 (3-button mode)
//   joy1, joy2  - player 1 / player 2 buttons, 1 = pressed
//   frame_valid - one-cycle pulse when a frame completes
//
// Optional feature macro: JOY_FILTER_EN. When it is defined, the outputs only update
// when two consecutive frames carry an identical raw word.

module zxtres_joy_db9_reader #(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned FRAME_GAP = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    output logic        joy_clk,
    output logic        joy_load_n,
    input  logic        joy_data,
    output logic        joy_select,
    output logic [11:0] joy1,
    output logic [11:0] joy2,
    output logic        frame_valid
);

    localparam int unsigned LOAD_CYC = 2 * CLK_DIV;
    localparam int unsigned CNT_MAX  = (FRAME_GAP > LOAD_CYC) ? FRAME_GAP : LOAD_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);
    localparam int unsigned BIT_W    = 5;
    localparam int unsigned NBITS    = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        UPDATE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;       // shared gap / load / divider counter
    logic [BIT_W-1:0]   bit_idx;
    logic [NBITS-1:0]   raw;
    logic [1:0]         sync;
    logic               data_s;
`ifdef JOY_FILTER_EN
    logic [NBITS-1:0]   hist;
`endif

    assign data_s     = sync[1];
    assign joy_select = 1'b1;

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], joy_data};
        end
    end

    // Frame sequencer with registered pin and output drivers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            raw         <= '0;
            joy_clk     <= 1'b0;
            joy_load_n  <= 1'b1;
            joy1        <= '0;
            joy2        <= '0;
            frame_valid <= 1'b0;
`ifdef JOY_FILTER_EN
            hist        <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cnt == CNT_W'(FRAME_GAP - 1)) begin
                        cnt        <= '0;
                        joy_load_n <= 1'b0;
                        state      <= LOAD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (cnt == CNT_W'(LOAD_CYC - 1)) begin
                        cnt        <= '0;
                        bit_idx    <= '0;
                        joy_load_n <= 1'b1;
                        state      <= SHIFT_LO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT_LO: begin
                    // Capture on the last low cycle; the synchronizer delay puts the
                    // effective pin sample two cycles earlier, still inside the low phase.
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt          <= '0;
                        raw[bit_idx] <= data_s;
                        joy_clk      <= 1'b1;
                        state        <= SHIFT_HI;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt     <= '0;
                        joy_clk <= 1'b0;
                        if (bit_idx == BIT_W'(NBITS - 1)) begin
                            // Outputs and the valid pulse appear together in the UPDATE cycle
                            frame_valid <= 1'b1;
`ifdef JOY_FILTER_EN
                            if (raw == hist) begin
                                joy1 <= ~raw[11:0];
                                joy2 <= ~raw[23:12];
                            end
                            hist <= raw;
`else
                            joy1 <= ~raw[11:0];
                            joy2 <= ~raw[23:12];
`endif
                            state <= UPDATE;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                UPDATE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
